multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle variant of the RV32I core.
- Sequences the shared datapath resources (single memory port, ALU, PC and IR registers, register-file write port, immediate generator select) through fetch / decode / execute / memory / writeback.
- Supports lw, sw, beq, R-type and I-type ALU instructions.
- Sits between the IR/ALU-flags and all datapath mux selects and write enables.

---
 rtl/multicycle_ctrl.sv | 156 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core: steps the shared memory port, ALU,
// PC/IR registers and register-file write port through fetch, decode, execute, memory and writeback.
module multicycle_ctrl #(
  parameter logic MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       retire,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_HALT
  } state_t;

  state_t state_q, state_d;

  logic rdy;
  logic pc_write_c, mem_read_c, mem_write_c, ir_write_c, reg_write_c, retire_c, halted_c;

  // Subtraction is only legal for register-register ops; addi with bit 30 set stays an add.
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_sel);
    case (f3)
      3'b000:  alu_dec = sub_sel ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: alu_dec = 3'b000;
    endcase
  endfunction

  assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    adr_src     = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    retire_c    = 1'b0;
    halted_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (rdy) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = S_BEQ;
          default:                state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        mem_read_c = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        if (rdy) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_dec(funct3, funct7b5);
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_dec(funct3, 1'b0);
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        pc_write_c  = zero;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT:  halted_c = 1'b1;
      default: state_d  = S_FETCH;
    endcase
  end

  // Reset sits in FETCH, whose read/load enables must not leak out while rst is held.
  assign pc_write  = pc_write_c  & ~rst;
  assign mem_read  = mem_read_c  & ~rst;
  assign mem_write = mem_write_c & ~rst;
  assign ir_write  = ir_write_c  & ~rst;
  assign reg_write = reg_write_c & ~rst;
  assign retire    = retire_c    & ~rst;
  assign halted    = halted_c    & ~rst;

  assign imm_src = (op == 7'b0100011) ? 2'b01 :
                   (op == 7'b1100011) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, multi-cycle corner
// sequences, and random instruction streams against a per-instruction step-list model.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       pc_write, adr_src, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       retire, halted;

  int errors = 0;
  int checks = 0;

  multicycle_ctrl #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
    .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_BAD = 7'b1111111;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [6:0] enables();
    return {pc_write, mem_read, mem_write, ir_write, reg_write, retire, halted};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, result_src,
            alu_src_a, alu_src_b, alu_control, imm_src, retire, halted};
  endfunction

  // Rst held for one clock edge; returns at a negedge with rst low, DUT in its fetch step.
  task automatic do_reset();
    rst = 1'b1;
    #1 chk("reset_enables", 32'(enables()), 32'd0);
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z, rdy;
    logic [4:0] en;   // {pc_write, mem_read, mem_write, reg_write, retire}
    logic [1:0] rs;
    logic [2:0] alu;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                              input logic z, input logic [4:0] en, input logic [1:0] rs,
                              input logic [2:0] alu);
    row_t r;
    r.op = o; r.f3 = f3; r.f7 = f7; r.z = z; r.rdy = 1'b1;
    r.en = en; r.rs = rs; r.alu = alu;
    return r;
  endfunction

  task automatic push_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic [2:0] exp_alu);
    tbl.push_back(mk(o, f3, f7, 1'b0, 5'b11000, 2'b10, 3'b000));
    tbl.push_back(mk(o, f3, f7, 1'b0, 5'b00000, 2'b00, 3'b000));
    tbl.push_back(mk(o, f3, f7, 1'b0, 5'b00000, 2'b00, exp_alu));
    tbl.push_back(mk(o, f3, f7, 1'b0, 5'b00011, 2'b00, 3'b000));
  endtask

  // ---------------- reference model ----------------
  // An instruction is a list of steps; memory steps repeat while mem_ready is low.
  localparam int K_F = 0, K_D = 1, K_MA = 2, K_MR = 3, K_MW = 4, K_MWB = 5,
                 K_XR = 6, K_XI = 7, K_WB = 8, K_B = 9, K_H = 10;

  function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic sub);
    logic [2:0] r;
    r = 3'b000;
    if (f3 == 3'b000 && sub) r = 3'b001;
    else if (f3 == 3'b010)   r = 3'b101;
    else if (f3 == 3'b110)   r = 3'b011;
    else if (f3 == 3'b111)   r = 3'b010;
    return r;
  endfunction

  function automatic logic [18:0] model(input int k, input logic rdy, input logic z,
                                        input logic [6:0] o, input logic [2:0] f3,
                                        input logic f7);
    logic pcw, adr, mrd, mwr, irw, rw, ret, hlt;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    {pcw, adr, mrd, mwr, irw, rw, ret, hlt} = 8'b0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
    imm = (o == OP_SW) ? 2'b01 : (o == OP_BEQ) ? 2'b10 : 2'b00;
    case (k)
      K_F:   begin mrd = 1'b1; sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
      K_D:   begin sa = 2'b01; sb = 2'b01; end
      K_MA:  begin sa = 2'b10; sb = 2'b01; end
      K_MR:  begin adr = 1'b1; mrd = 1'b1; end
      K_MW:  begin adr = 1'b1; mwr = 1'b1; ret = rdy; end
      K_MWB: begin rs = 2'b01; rw = 1'b1; ret = 1'b1; end
      K_XR:  begin sa = 2'b10; alu = ref_alu(f3, f7); end
      K_XI:  begin sa = 2'b10; sb = 2'b01; alu = ref_alu(f3, 1'b0); end
      K_WB:  begin rw = 1'b1; ret = 1'b1; end
      K_B:   begin sa = 2'b10; alu = 3'b001; pcw = z; ret = 1'b1; end
      default: hlt = 1'b1;
    endcase
    return {pcw, adr, mrd, mwr, irw, rw, rs, sa, sb, alu, imm, ret, hlt};
  endfunction

  initial begin
    int steps[$];
    rst = 1'b1; op = OP_LW; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;

    // ---- table: lw, ALU decodes, beq taken / not taken ----
    tbl.push_back(mk(OP_LW, 3'b010, 1'b0, 1'b0, 5'b11000, 2'b10, 3'b000));
    tbl.push_back(mk(OP_LW, 3'b010, 1'b0, 1'b0, 5'b00000, 2'b00, 3'b000));
    tbl.push_back(mk(OP_LW, 3'b010, 1'b0, 1'b0, 5'b00000, 2'b00, 3'b000));
    tbl.push_back(mk(OP_LW, 3'b010, 1'b0, 1'b0, 5'b01000, 2'b00, 3'b000));
    tbl.push_back(mk(OP_LW, 3'b010, 1'b0, 1'b0, 5'b00011, 2'b01, 3'b000));
    push_alu(OP_R, 3'b000, 1'b1, 3'b001);
    push_alu(OP_I, 3'b000, 1'b1, 3'b000);
    push_alu(OP_R, 3'b111, 1'b0, 3'b010);
    push_alu(OP_I, 3'b110, 1'b0, 3'b011);
    push_alu(OP_R, 3'b010, 1'b0, 3'b101);
    for (int z = 1; z >= 0; z--) begin
      tbl.push_back(mk(OP_BEQ, 3'b000, 1'b0, 1'(z), 5'b11000, 2'b10, 3'b000));
      tbl.push_back(mk(OP_BEQ, 3'b000, 1'b0, 1'(z), 5'b00000, 2'b00, 3'b000));
      tbl.push_back(mk(OP_BEQ, 3'b000, 1'b0, 1'(z), {1'(z), 4'b0001}, 2'b00, 3'b001));
    end

    tick();
    do_reset();
    foreach (tbl[i]) begin
      op = tbl[i].op; funct3 = tbl[i].f3; funct7b5 = tbl[i].f7;
      zero = tbl[i].z; mem_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_en", i), 32'({pc_write, mem_read, mem_write, reg_write, retire}),
          32'(tbl[i].en));
      chk($sformatf("tbl%0d_rs", i), 32'(result_src), 32'(tbl[i].rs));
      chk($sformatf("tbl%0d_alu", i), 32'(alu_control), 32'(tbl[i].alu));
      tick();
    end

    // ---- sw with two wait cycles in the write step ----
    op = OP_SW; funct3 = 3'b010; mem_ready = 1'b1;
    #1 chk("sw_fetch_irw", 32'(ir_write), 32'd1);
    chk("sw_imm_src", 32'(imm_src), 32'd1);
    tick(); tick(); tick();
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2);
      #1;
      chk($sformatf("sw_wait%0d_mwr", i), 32'(mem_write), 32'd1);
      chk($sformatf("sw_wait%0d_ret", i), 32'(retire), 32'(i == 2));
      chk($sformatf("sw_wait%0d_rw", i), 32'(reg_write), 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    #1 chk("sw_next_fetch", 32'({mem_read, ir_write, mem_write}), 32'b110);
    tick();

    // ---- illegal opcode halts, rst recovers ----
    do_reset();
    op = OP_BAD;
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom); zero = 1'($urandom);
      #1 chk($sformatf("halt%0d", i), 32'(dut_vec()), 32'd1);
      tick();
    end
    mem_ready = 1'b1;
    do_reset();
    #1 chk("halt_cleared", 32'(enables()), 32'b1101000);

    // ---- reset while lw waits in its read step ----
    op = OP_LW;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1 chk("mr_wait_read", 32'({adr_src, mem_read}), 32'b11);
    tick();
    #2 rst = 1'b1;
    #1 chk("mr_rst_enables", 32'(enables()), 32'd0);
    tick();
    rst = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("mr_relw%0d", i), 32'({reg_write, retire}), (i == 4) ? 32'b11 : 32'b00);
      tick();
    end

    // ---- random instruction stream against the step-list model ----
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (steps.size() == 0) begin
        int kind;
        kind = $urandom_range(0, 4);
        funct3 = 3'($urandom); funct7b5 = 1'($urandom);
        case (kind)
          0: begin op = OP_LW;  steps = '{K_F, K_D, K_MA, K_MR, K_MWB}; end
          1: begin op = OP_SW;  steps = '{K_F, K_D, K_MA, K_MW}; end
          2: begin op = OP_R;   steps = '{K_F, K_D, K_XR, K_WB}; end
          3: begin op = OP_I;   steps = '{K_F, K_D, K_XI, K_WB}; end
          default: begin op = OP_BEQ; steps = '{K_F, K_D, K_B}; end
        endcase
      end
      mem_ready = ($urandom_range(0, 9) < 7);
      zero = 1'($urandom);
      #1 chk($sformatf("rand%0d_k%0d", c, steps[0]), 32'(dut_vec()),
             32'(model(steps[0], mem_ready, zero, op, funct3, funct7b5)));
      if (!((steps[0] == K_F || steps[0] == K_MR || steps[0] == K_MW) && !mem_ready))
        void'(steps.pop_front());
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
